// File: rtl/step_position_tracker.sv
// Signed step-position counter with synchronised step input, limits (saturate or wrap),
// preset load/clear and target compare. Define STEP_TRACKER_VELOCITY_EN to add the windowed velocity output.
module step_position_tracker #(
  parameter int WIDTH       = 10,
  parameter int MIN_COUNT   = -(2**(WIDTH-1)),
  parameter int MAX_COUNT   = 2**(WIDTH-1)-1,
  parameter bit WRAP        = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter int VEL_WINDOW  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  input  logic             count_up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count,
  output logic             at_min,
  output logic             at_max,
  output logic             at_target,
  output logic             limit_hit
`ifdef STEP_TRACKER_VELOCITY_EN
  ,
  output logic [WIDTH-1:0] velocity,
  output logic             velocity_valid
`endif
);

  localparam logic signed [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_COUNT);
  localparam logic signed [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_COUNT);
  localparam logic signed [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
  localparam logic        [WIDTH-1:0] MIN_W = MIN_X[WIDTH-1:0];
  localparam logic        [WIDTH-1:0] MAX_W = MAX_X[WIDTH-1:0];

  if (SYNC_STAGES < 2 || MIN_COUNT >= MAX_COUNT || VEL_WINDOW < 1) begin : g_param_check
    $error("step_position_tracker: invalid parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   step_evt;
  logic                   move;
  logic                   at_edge;
  logic                   changed;
  logic signed [WIDTH:0]  cnt_x;
  logic signed [WIDTH:0]  lv_x;
  logic [WIDTH-1:0]       step_d;
  logic [WIDTH-1:0]       load_d;

  assign step_evt = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign move     = step_evt & enable;
  // One guard bit keeps +1/-1 and the limit compares from overflowing at full-range limits.
  assign cnt_x    = $signed({count[WIDTH-1], count});
  assign lv_x     = $signed({load_value[WIDTH-1], load_value});

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    at_edge = 1'b0;
    step_d  = count;
    if (count_up) begin
      at_edge = (cnt_x >= MAX_X);
      if (!at_edge)  step_d = WIDTH'(cnt_x + ONE_X);
      else if (WRAP) step_d = MIN_W;
    end else begin
      at_edge = (cnt_x <= MIN_X);
      if (!at_edge)  step_d = WIDTH'(cnt_x - ONE_X);
      else if (WRAP) step_d = MAX_W;
    end
  end

  always_comb begin
    load_d = load_value;
    if (lv_x < MIN_X)      load_d = MIN_W;
    else if (lv_x > MAX_X) load_d = MAX_W;
  end

  // A step only reaches the count when nothing of higher priority claims the cycle.
  assign changed = move & ~clear & ~load & (~at_edge | WRAP);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      count     <= '0;
      limit_hit <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], step};
      hist_q <= sync_q[SYNC_STAGES-1];
      if (clear) begin
        count     <= '0;
        limit_hit <= 1'b0;
      end else if (load) begin
        count     <= load_d;
        limit_hit <= 1'b0;
      end else if (move) begin
        count <= step_d;
        if (at_edge) limit_hit <= 1'b1;
      end
    end
  end

  assign at_min    = (count == MIN_W);
  assign at_max    = (count == MAX_W);
  assign at_target = (count == target);

`ifdef STEP_TRACKER_VELOCITY_EN
  localparam int WW = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
  localparam logic signed [WIDTH:0] ACC_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] ACC_MIN = {2'b11, {(WIDTH-1){1'b0}}};

  logic [WW-1:0]          win_q;
  logic [WIDTH-1:0]       acc_q;
  logic signed [WIDTH:0]  delta_x;
  logic signed [WIDTH:0]  acc_x;
  logic [WIDTH-1:0]       acc_d;
  logic                   last;

  assign last    = (win_q == WW'(VEL_WINDOW-1));
  assign delta_x = !changed ? '0 : (count_up ? ONE_X : -ONE_X);
  assign acc_x   = $signed({acc_q[WIDTH-1], acc_q}) + delta_x;

  always_comb begin
    acc_d = WIDTH'(acc_x);
    if (acc_x > ACC_MAX)      acc_d = ACC_MAX[WIDTH-1:0];
    else if (acc_x < ACC_MIN) acc_d = ACC_MIN[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q          <= '0;
      acc_q          <= '0;
      velocity       <= '0;
      velocity_valid <= 1'b0;
    end else if (clear || load) begin
      win_q          <= '0;
      acc_q          <= '0;
      velocity_valid <= 1'b0;
    end else if (last) begin
      win_q          <= '0;
      acc_q          <= '0;
      velocity       <= acc_d;
      velocity_valid <= 1'b1;
    end else begin
      win_q          <= win_q + WW'(1);
      acc_q          <= acc_d;
      velocity_valid <= 1'b0;
    end
  end
`endif

endmodule
